jt89_noise_gen: RTL and testbench

Parametrised noise channel for the JT89 PSG family. It uses a configurable-width LFSR with a selectable white-noise tap and four shift-rate modes, one of which is driven by tone channel 2. A 2 dB attenuation table produces the channel amplitude. It replaces the fixed 16-bit noise channel and adds a control-write strobe, optional reseed-on-write, and zero-lock recovery.

---
 rtl/jt89_noise_gen.sv | 187 ++++++++++++++++++
 tb/tb_jt89_noise_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/jt89_noise_gen.sv
// jt89_noise_gen -- noise channel for the JT89 PSG family.
//
// A configurable-width LFSR is clocked at one of three divided rates or by
// rising edges of tone channel 2. It runs in white mode (feedback from bit 0
// XOR bit TAP) or periodic mode (bit 0 recirculated). An all-zero register
// is never shifted; SEED is loaded instead so the channel cannot lock up.
// Bit 0 gates a 2 dB attenuation table to give the channel amplitude.
//
// Compile-time option:
//   JT89_NOISE_RESEED_EN - every control write reloads SEED into the LFSR
//                          and restarts the divider, as the original SN76489
//                          does. When it is left undefined, a write only
//                          changes the control register, as clone parts do.

module jt89_noise_gen #(
    parameter int                LFSR_W   = 16,
    parameter int                TAP      = 3,
    parameter logic [LFSR_W-1:0] SEED     = {1'b1, {(LFSR_W-1){1'b0}}},
    parameter int                DIV_BASE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       ctrl_we,
    input  logic [2:0] ctrl_din,
    input  logic [3:0] vol,
    input  logic       tone_in,
    output logic       noise_bit,
    output logic [7:0] snd
);

    localparam int CNT_W = DIV_BASE + 2;

    // Divider reload value (N-1) for a rate code. The tone-driven rate never
    // counts, so it gets the widest value.
    function automatic logic [CNT_W-1:0] reload_val(input logic [1:0] rate);
        logic [CNT_W-1:0] v;
        case (rate)
            2'd0:    v = {CNT_W{1'b1}} >> 2;
            2'd1:    v = {CNT_W{1'b1}} >> 1;
            2'd2:    v = {CNT_W{1'b1}};
            default: v = {CNT_W{1'b1}};
        endcase
        return v;
    endfunction

    // 2 dB per step attenuation table, 0 = loudest, 15 = silent.
    function automatic logic [7:0] amp_val(input logic [3:0] att);
        logic [7:0] a;
        case (att)
            4'd0:    a = 8'd255;
            4'd1:    a = 8'd203;
            4'd2:    a = 8'd161;
            4'd3:    a = 8'd128;
            4'd4:    a = 8'd102;
            4'd5:    a = 8'd81;
            4'd6:    a = 8'd64;
            4'd7:    a = 8'd51;
            4'd8:    a = 8'd40;
            4'd9:    a = 8'd32;
            4'd10:   a = 8'd26;
            4'd11:   a = 8'd20;
            4'd12:   a = 8'd16;
            4'd13:   a = 8'd13;
            4'd14:   a = 8'd10;
            default: a = 8'd0;
        endcase
        return a;
    endfunction

    logic [2:0]        ctrl_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              last_tone_r;
    logic [LFSR_W-1:0] shift_r;
    logic [7:0]        snd_r;

    logic [1:0]        rate_s;
    logic              tick_s;
    logic              fb_s;
    logic [LFSR_W-1:0] shift_adv_s;
    logic [CNT_W-1:0]  cnt_adv_s;
    logic              reseed_s;

`ifdef JT89_NOISE_RESEED_EN
    assign reseed_s = ctrl_we;
`else
    assign reseed_s = 1'b0;
`endif

    // Shift tick, feedback and divider next-state, all from the old ctrl.
    always_comb begin
        rate_s      = ctrl_r[1:0];
        tick_s      = 1'b0;
        fb_s        = shift_r[0];
        shift_adv_s = shift_r;
        cnt_adv_s   = cnt_r;

        if (rate_s == 2'd3) begin
            tick_s = cen & tone_in & ~last_tone_r;
        end else begin
            tick_s = cen & (cnt_r == {CNT_W{1'b0}});
        end

        if (ctrl_r[2]) begin
            fb_s = shift_r[0] ^ shift_r[TAP];
        end else begin
            fb_s = shift_r[0];
        end

        if (shift_r == {LFSR_W{1'b0}}) begin
            shift_adv_s = SEED;
        end else begin
            shift_adv_s = {fb_s, shift_r[LFSR_W-1:1]};
        end

        if (!cen) begin
            cnt_adv_s = cnt_r;
        end else if (rate_s == 2'd3) begin
            cnt_adv_s = cnt_r;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
            cnt_adv_s = reload_val(rate_s);
        end else begin
            cnt_adv_s = cnt_r - CNT_W'(1);
        end
    end

    // Control register: latched on any write, independent of cen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r <= 3'b000;
        end else if (ctrl_we) begin
            ctrl_r <= ctrl_din;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // Rate divider; a reseeding write restarts it at the new rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= reload_val(2'd0);
        end else if (reseed_s) begin
            cnt_r <= reload_val(ctrl_din[1:0]);
        end else begin
            cnt_r <= cnt_adv_s;
        end
    end

    // Tone sample for edge detection, taken on every cen in all modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_tone_r <= 1'b0;
        end else if (cen) begin
            last_tone_r <= tone_in;
        end else begin
            last_tone_r <= last_tone_r;
        end
    end

    // LFSR: a reseed beats a tick landing in the same clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= SEED;
        end else if (reseed_s) begin
            shift_r <= SEED;
        end else if (tick_s) begin
            shift_r <= shift_adv_s;
        end else begin
            shift_r <= shift_r;
        end
    end

    // Amplitude output, one cen behind noise_bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd_r <= 8'd0;
        end else if (cen) begin
            snd_r <= shift_r[0] ? amp_val(vol) : 8'd0;
        end else begin
            snd_r <= snd_r;
        end
    end

    assign noise_bit = shift_r[0];
    assign snd       = snd_r;

endmodule

// File: tb/tb_jt89_noise_gen.sv
// tb_jt89_noise_gen -- directed bench for jt89_noise_gen at default parameters.
// Honours JT89_NOISE_RESEED_EN the same way the design does.

module tb_jt89_noise_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       ctrl_we;
    logic [2:0] ctrl_din;
    logic [3:0] vol;
    logic       tone_in;
    logic       noise_bit;
    logic [7:0] snd;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model;

`ifdef JT89_NOISE_RESEED_EN
    localparam int T_UP = 960;
`else
    localparam int T_UP = 912;
`endif

    jt89_noise_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .ctrl_we   (ctrl_we),
        .ctrl_din  (ctrl_din),
        .vol       (vol),
        .tone_in   (tone_in),
        .noise_bit (noise_bit),
        .snd       (snd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cen_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) cen = 1'b1;
            @(negedge clk) cen = 1'b0;
        end
    endtask

    task automatic write_ctrl(input logic [2:0] v);
        @(negedge clk);
        ctrl_we  = 1'b1;
        ctrl_din = v;
        @(negedge clk);
        ctrl_we  = 1'b0;
`ifdef JT89_NOISE_RESEED_EN
        model = 16'h8000;
`endif
    endtask

    task automatic model_white_step();
        model = {model[0] ^ model[3], model[15:1]};
    endtask

    initial begin
        logic t_now;
        logic t_prev;

        rst_n    = 1'b0;
        cen      = 1'b0;
        ctrl_we  = 1'b0;
        ctrl_din = 3'b000;
        vol      = 4'd0;
        tone_in  = 1'b0;
        model    = 16'h8000;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_noise_bit", noise_bit, 1'b0);
        check("rst_snd", snd, 8'd0);
        rst_n = 1'b1;

        // Rate 0 periodic from reset: shift 15 lands on cen 240
        cen_pulses(239);
        check("nb_before_shift15", noise_bit, 1'b0);
        cen_pulses(1);
        check("nb_at_shift15", noise_bit, 1'b1);
        check("snd_lags_nb", snd, 8'd0);
        cen_pulses(1);
        check("snd_vol0", snd, 8'd255);
        vol = 4'd15;
        cen_pulses(1);
        check("snd_vol15", snd, 8'd0);
        vol = 4'd3;
        cen_pulses(1);
        check("snd_vol3", snd, 8'd128);
        vol = 4'd9;
        cen_pulses(1);
        check("snd_vol9", snd, 8'd32);
        vol = 4'd0;
        cen_pulses(11);
        check("nb_before_shift16", noise_bit, 1'b1);
        cen_pulses(1);
        check("nb_at_shift16", noise_bit, 1'b0);

        // Periodic mode: high exactly on shift 15 of every 16
        for (int s = 17; s <= 48; s++) begin
            cen_pulses(16);
            check("periodic", noise_bit, 32'((s % 16) == 15));
        end

        // Rate 2 (64 cen per shift); without reseed the change waits for reload
        write_ctrl(3'b010);
        cen_pulses(T_UP - 1);
        check("rate2_before_up", noise_bit, 1'b0);
        cen_pulses(1);
        check("rate2_up", noise_bit, 1'b1);
        cen_pulses(63);
        check("rate2_hold", noise_bit, 1'b1);
        check("snd_high", snd, 8'd255);
        cen_pulses(1);
        check("rate2_down", noise_bit, 1'b0);
        check("snd_after_down", snd, 8'd255);

        // Asynchronous reset mid-operation
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_snd", snd, 8'd0);
        check("midrst_nb", noise_bit, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // White mode, 20 shifts against the software model
        model = 16'h8000;
        write_ctrl(3'b100);
        for (int s = 1; s <= 20; s++) begin
            cen_pulses(16);
            model_white_step();
            check("white", noise_bit, model[0]);
        end

        // Tone-driven rate: 5 rising edges in 100 cen, one long high level
        write_ctrl(3'b111);
        t_prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            t_now = ((i >= 10) && (i < 13)) || ((i >= 30) && (i < 32)) || (i == 50) ||
                    ((i >= 70) && (i < 86)) || ((i >= 95) && (i < 98));
            tone_in = t_now;
            cen_pulses(1);
            if (t_now && !t_prev) begin
                model_white_step();
                check("tone_shift", noise_bit, model[0]);
            end
            t_prev = t_now;
        end
        tone_in = 1'b0;

        // Back to rate 0; the following sequence exposes the tone shift count
        write_ctrl(3'b100);
        for (int s = 1; s <= 8; s++) begin
            cen_pulses(16);
            model_white_step();
            check("post_tone", noise_bit, model[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
